// File: rtl/multicycle_control_unit_if.sv
// Control-unit bus: opcode/memory-ready inputs and the datapath control strobes.
// The slave side is the control unit; the master side is the datapath driving it.
interface multicycle_control_unit_if #(
    parameter int OPCODE_W = 6,
    parameter int CNT_W    = 16
);
    logic [OPCODE_W-1:0] Opcode;
    logic                MemReady;
    logic                PCWrite;
    logic                PCWriteCond;
    logic                IorD;
    logic                MemRead;
    logic                MemWrite;
    logic                MemtoReg;
    logic                IRWrite;
    logic                RegWrite;
    logic                RegDst;
    logic                ALUSrcA;
    logic [1:0]          ALUSrcB;
    logic [1:0]          ALUOp;
    logic [1:0]          PCSource;
    logic [3:0]          State;
    logic                Illegal;
    logic [CNT_W-1:0]    InstrCount;

    modport master (
        output Opcode, MemReady,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
               RegWrite, RegDst, ALUSrcA, ALUSrcB, ALUOp, PCSource, State,
               Illegal, InstrCount
    );

    modport slave (
        input  Opcode, MemReady,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
               RegWrite, RegDst, ALUSrcA, ALUSrcB, ALUOp, PCSource, State,
               Illegal, InstrCount
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS-style control FSM: state-decoded datapath strobes, memory
// wait handling, opcode capture at DECODE and a retired-instruction counter.
module multicycle_control_unit #(
    parameter int                     OPCODE_W = 6,
    parameter int                     CNT_W    = 16,
    parameter logic [OPCODE_W-1:0]    OP_RTYPE = 6'b000000,
    parameter logic [OPCODE_W-1:0]    OP_LW    = 6'b100011,
    parameter logic [OPCODE_W-1:0]    OP_SW    = 6'b101011,
    parameter logic [OPCODE_W-1:0]    OP_BEQ   = 6'b000100,
    parameter logic [OPCODE_W-1:0]    OP_J     = 6'b010000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    multicycle_control_unit_if.slave  bus
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9
    } state_t;

    state_t              state_q, state_d;
    logic [OPCODE_W-1:0] op_q;
    logic [CNT_W-1:0]    count_q;
    logic                cnt_inc;

    logic                pc_write, pc_write_cond, i_or_d, mem_read, mem_write;
    logic                mem_to_reg, ir_write, reg_write, reg_dst, alu_src_a;
    logic [1:0]          alu_src_b, alu_op, pc_source;
    logic                illegal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            op_q    <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE)
                op_q <= bus.Opcode;
            if (cnt_inc)
                count_q <= count_q + CNT_W'(1);
        end
    end

    always_comb begin
        state_d       = S_FETCH;
        cnt_inc       = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_to_reg    = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;
        illegal       = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = bus.MemReady;
                pc_write  = bus.MemReady;
                state_d   = bus.MemReady ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                case (bus.Opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        illegal = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                // Load vs store is decided from the opcode captured in DECODE
                state_d   = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                state_d  = bus.MemReady ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                cnt_inc    = 1'b1;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                cnt_inc   = bus.MemReady;
                state_d   = bus.MemReady ? S_FETCH : S_MEMWR;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                state_d   = S_RWB;
            end
            S_RWB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
                cnt_inc   = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                cnt_inc       = 1'b1;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
                cnt_inc   = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Write/read strobes are held off while reset is asserted
    assign bus.PCWrite     = pc_write & rst_n;
    assign bus.PCWriteCond = pc_write_cond & rst_n;
    assign bus.MemRead     = mem_read & rst_n;
    assign bus.MemWrite    = mem_write & rst_n;
    assign bus.IRWrite     = ir_write & rst_n;
    assign bus.RegWrite    = reg_write & rst_n;
    assign bus.Illegal     = illegal & rst_n;
    assign bus.IorD        = i_or_d;
    assign bus.MemtoReg    = mem_to_reg;
    assign bus.RegDst      = reg_dst;
    assign bus.ALUSrcA     = alu_src_a;
    assign bus.ALUSrcB     = alu_src_b;
    assign bus.ALUOp       = alu_op;
    assign bus.PCSource    = pc_source;
    assign bus.State       = state_q;
    assign bus.InstrCount  = count_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: per-cycle vector table plus
// hand-written counter-wrap and mid-instruction reset sequences.
module tb_multicycle_control_unit;

    localparam logic [5:0] RT  = 6'b000000;
    localparam logic [5:0] LW  = 6'b100011;
    localparam logic [5:0] SW  = 6'b101011;
    localparam logic [5:0] BQ  = 6'b000100;
    localparam logic [5:0] JP  = 6'b010000;
    localparam logic [5:0] ILL = 6'b111111;

    // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,MemtoReg,IRWrite,RegWrite,RegDst,ALUSrcA,ALUSrcB,ALUOp,PCSource,Illegal}
    localparam logic [16:0] C_FR   = 17'b1_0_0_1_0_0_1_0_0_0_01_00_00_0;
    localparam logic [16:0] C_FW   = 17'b0_0_0_1_0_0_0_0_0_0_01_00_00_0;
    localparam logic [16:0] C_DEC  = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_0;
    localparam logic [16:0] C_DILL = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_1;
    localparam logic [16:0] C_MA   = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
    localparam logic [16:0] C_MR   = 17'b0_0_1_1_0_0_0_0_0_0_00_00_00_0;
    localparam logic [16:0] C_WB   = 17'b0_0_0_0_0_1_0_1_0_0_00_00_00_0;
    localparam logic [16:0] C_MW   = 17'b0_0_1_0_1_0_0_0_0_0_00_00_00_0;
    localparam logic [16:0] C_EX   = 17'b0_0_0_0_0_0_0_0_0_1_00_10_00_0;
    localparam logic [16:0] C_RWB  = 17'b0_0_0_0_0_0_0_1_1_0_00_00_00_0;
    localparam logic [16:0] C_BR   = 17'b0_1_0_0_0_0_0_0_0_1_00_01_01_0;
    localparam logic [16:0] C_JP   = 17'b1_0_0_0_0_0_0_0_0_0_00_00_10_0;
    localparam logic [16:0] C_RST  = 17'b0_0_0_0_0_0_0_0_0_0_01_00_00_0;

    typedef struct packed {
        logic [5:0]  op;
        logic        rdy;
        logic [3:0]  st;
        logic [16:0] ctrl;
        logic [3:0]  cnt;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    multicycle_control_unit_if #(.OPCODE_W(6), .CNT_W(4)) bus ();

    multicycle_control_unit #(.OPCODE_W(6), .CNT_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [16:0] ctrl;
    assign ctrl = {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite,
                   bus.MemtoReg, bus.IRWrite, bus.RegWrite, bus.RegDst, bus.ALUSrcA,
                   bus.ALUSrcB, bus.ALUOp, bus.PCSource, bus.Illegal};

    task automatic check(input string name, input int idx, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s [%0d]: got 0x%0h, expected 0x%0h", name, idx, got, exp);
        end
    endtask

    // One clock of stimulus: drive after posedge, check at negedge
    task automatic cyc(input logic [5:0] op, input logic rdy, input logic [3:0] st,
                       input logic [16:0] c, input logic [3:0] cn, input int idx);
        bus.Opcode   = op;
        bus.MemReady = rdy;
        @(negedge clk);
        check("state", idx, 32'(bus.State), 32'(st));
        check("ctrl",  idx, 32'(ctrl), 32'(c));
        check("count", idx, 32'(bus.InstrCount), 32'(cn));
        @(posedge clk);
        #1;
    endtask

    vec_t tbl [27];

    initial begin
        tbl[0]  = '{RT,  1'b1, 4'd0, C_FR,   4'd0};
        tbl[1]  = '{RT,  1'b0, 4'd1, C_DEC,  4'd0};
        tbl[2]  = '{RT,  1'b0, 4'd6, C_EX,   4'd0};
        tbl[3]  = '{RT,  1'b1, 4'd7, C_RWB,  4'd0};
        tbl[4]  = '{LW,  1'b1, 4'd0, C_FR,   4'd1};
        tbl[5]  = '{LW,  1'b1, 4'd1, C_DEC,  4'd1};
        tbl[6]  = '{LW,  1'b0, 4'd2, C_MA,   4'd1};
        tbl[7]  = '{LW,  1'b0, 4'd3, C_MR,   4'd1};
        tbl[8]  = '{LW,  1'b0, 4'd3, C_MR,   4'd1};
        tbl[9]  = '{LW,  1'b0, 4'd3, C_MR,   4'd1};
        tbl[10] = '{LW,  1'b1, 4'd3, C_MR,   4'd1};
        tbl[11] = '{LW,  1'b0, 4'd4, C_WB,   4'd1};
        tbl[12] = '{SW,  1'b0, 4'd0, C_FW,   4'd2};
        tbl[13] = '{SW,  1'b0, 4'd0, C_FW,   4'd2};
        tbl[14] = '{SW,  1'b1, 4'd0, C_FR,   4'd2};
        tbl[15] = '{SW,  1'b1, 4'd1, C_DEC,  4'd2};
        tbl[16] = '{BQ,  1'b1, 4'd2, C_MA,   4'd2};
        tbl[17] = '{BQ,  1'b0, 4'd5, C_MW,   4'd2};
        tbl[18] = '{BQ,  1'b1, 4'd5, C_MW,   4'd2};
        tbl[19] = '{ILL, 1'b1, 4'd0, C_FR,   4'd3};
        tbl[20] = '{ILL, 1'b1, 4'd1, C_DILL, 4'd3};
        tbl[21] = '{JP,  1'b1, 4'd0, C_FR,   4'd3};
        tbl[22] = '{JP,  1'b1, 4'd1, C_DEC,  4'd3};
        tbl[23] = '{JP,  1'b0, 4'd9, C_JP,   4'd3};
        tbl[24] = '{BQ,  1'b1, 4'd0, C_FR,   4'd4};
        tbl[25] = '{BQ,  1'b0, 4'd1, C_DEC,  4'd4};
        tbl[26] = '{BQ,  1'b0, 4'd8, C_BR,   4'd4};

        rst_n        = 1'b1;
        bus.Opcode   = RT;
        bus.MemReady = 1'b1;
        #1 rst_n = 1'b0;
        @(negedge clk);
        check("rst_state", 0, 32'(bus.State), 32'd0);
        check("rst_ctrl",  0, 32'(ctrl), 32'(C_RST));
        check("rst_count", 0, 32'(bus.InstrCount), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 27; i++)
            cyc(tbl[i].op, tbl[i].rdy, tbl[i].st, tbl[i].ctrl, tbl[i].cnt, i);

        // Eleven more branches take the 4-bit counter from 5 through 15 and back to 0
        for (int i = 0; i < 11; i++) begin
            cyc(BQ, 1'b1, 4'd0, C_FR,  4'(5 + i), 100 + i);
            cyc(BQ, 1'b1, 4'd1, C_DEC, 4'(5 + i), 100 + i);
            cyc(BQ, 1'b1, 4'd8, C_BR,  4'(5 + i), 100 + i);
        end
        cyc(RT, 1'b1, 4'd0, C_FR,  4'd0, 200);
        cyc(RT, 1'b1, 4'd1, C_DEC, 4'd0, 201);
        cyc(RT, 1'b1, 4'd6, C_EX,  4'd0, 202);
        cyc(RT, 1'b1, 4'd7, C_RWB, 4'd0, 203);
        cyc(LW, 1'b1, 4'd0, C_FR,  4'd1, 204);
        cyc(LW, 1'b1, 4'd1, C_DEC, 4'd1, 205);
        cyc(LW, 1'b0, 4'd2, C_MA,  4'd1, 206);
        cyc(LW, 1'b0, 4'd3, C_MR,  4'd1, 207);

        // Abort a load stalled in MEMRD with an asynchronous reset pulse
        #2 rst_n = 1'b0;
        #1;
        check("abort_state", 300, 32'(bus.State), 32'd0);
        check("abort_ctrl",  300, 32'(ctrl), 32'(C_RST));
        check("abort_count", 300, 32'(bus.InstrCount), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        cyc(RT, 1'b1, 4'd0, C_FR,  4'd0, 301);
        cyc(RT, 1'b1, 4'd1, C_DEC, 4'd0, 302);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_control_unit.md
MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 SHALL have parameter OPCODE_W, default 6, opcode field width.
REQ-002 SHALL have parameter CNT_W, default 16, retired-instruction counter width.
REQ-003 SHALL have parameters OP_RTYPE 6'b000000, OP_LW 6'b100011, OP_SW 6'b101011, OP_BEQ 6'b000100, OP_J 6'b010000, the opcode values decoded (each OPCODE_W wide).
REQ-004 SHALL have ports: clk  in  1  rising-edge clock; rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports: Opcode  in  OPCODE_W  current IR opcode; MemReady  in  1  memory access complete this cycle.
REQ-006 SHALL have ports: PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, RegWrite, RegDst, ALUSrcA  out  1 each  datapath controls.
REQ-007 SHALL have ports: ALUSrcB  out  2  (00 regB, 01 const 4, 10 signext imm, 11 imm<<2); ALUOp  out  2; PCSource  out  2  (00 ALU, 01 ALUOut, 10 jump target).
REQ-008 SHALL have ports: State  out  4  current state code; Illegal  out  1  unknown opcode; InstrCount  out  CNT_W  retired instructions.

Function
REQ-009 SHALL implement a 4-bit state register: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, JUMP=9; codes 10-15 go to FETCH next cycle with all strobes 0.
REQ-010 SHALL decode outputs combinationally from State (plus MemReady where stated); unlisted outputs are 0.
REQ-011 FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00, IRWrite=PCWrite=MemReady; stays in FETCH while MemReady=0, goes to DECODE when MemReady=1.
REQ-012 DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00; next state from Opcode: OP_LW/OP_SW->MEMADR, OP_RTYPE->EXEC, OP_BEQ->BRANCH, OP_J->JUMP, any other->FETCH.
REQ-013 DECODE with an unmatched Opcode SHALL drive Illegal=1 for that cycle; Illegal is 0 in every other state.
REQ-014 MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00; next MEMRD if the Opcode latched in DECODE was OP_LW, else MEMWR.
REQ-015 SHALL latch Opcode on leaving DECODE; later states use only the latched value, never the live input.
REQ-016 MEMRD: MemRead=1, IorD=1; waits while MemReady=0; MemReady=1 -> MEMWB.
REQ-017 MEMWB: RegDst=0, MemtoReg=1, RegWrite=1; -> FETCH.
REQ-018 MEMWR: MemWrite=1, IorD=1; waits while MemReady=0; MemReady=1 -> FETCH.
REQ-019 EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10; -> RWB.  RWB: RegDst=1, MemtoReg=0, RegWrite=1; -> FETCH.
REQ-020 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01; -> FETCH.
REQ-021 JUMP: PCWrite=1, PCSource=10; -> FETCH.
REQ-022 SHALL increment InstrCount by 1 on each transition into FETCH from MEMWB, MEMWR, RWB, BRANCH or JUMP; illegal returns from DECODE and returns from invalid state codes do not count; wraps from 2^CNT_W-1 to 0.
REQ-023 MemReady is ignored outside FETCH, MEMRD and MEMWR.
REQ-024 Latency (MemReady always 1): R-type 4 cycles, lw 5, sw 4, beq 3, j 3, illegal 2.

Reset
REQ-025 rst_n=0 SHALL asynchronously set State=FETCH, InstrCount=0 and the latched opcode to 0.
REQ-026 While rst_n=0, PCWrite, PCWriteCond, MemRead, MemWrite, IRWrite and RegWrite SHALL be forced to 0 and Illegal SHALL be 0; all other outputs take their FETCH values.
REQ-027 Reset asserted mid-instruction (any state, any wait) SHALL abort it with no count increment; the first cycle after release is FETCH.

Verification
REQ-028 Reset release, MemReady=1, Opcode=000000 -> State 0,1,6,7,0; RegWrite=1 only in state 7; InstrCount=1.
REQ-029 lw with MemReady low for 3 cycles in MEMRD -> State 0,1,2,3,3,3,3,4,0; MemRead=1 and IorD=1 throughout state 3; RegWrite/MemtoReg=1 in state 4.
REQ-030 FETCH with MemReady=0 for 2 cycles -> IRWrite=PCWrite=0 while waiting, both 1 for exactly one cycle when MemReady=1.
REQ-031 Opcode=6'b111111 -> Illegal=1 in DECODE only, back to FETCH, InstrCount unchanged; then Opcode=010000 -> PCWrite=1, PCSource=10 in JUMP.
REQ-032 Opcode changes from 101011 to 000100 during MEMADR -> still MEMWR with MemWrite=1 (latched opcode used).
REQ-033 CNT_W=4, 16 beq instructions -> InstrCount wraps to 0; rst_n pulsed low in MEMRD -> State=0, all strobes 0 immediately, InstrCount=0.
